// File: rtl/aes_block_loader.sv
// aes_block_loader: byte-serial loader that packs 16 key bytes and 16
// plaintext bytes into 128-bit words and presents them as one block.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. Ready and valid outputs are decoded from state only, never from
// the partner's valid/ready; an offered byte or block that is not taken
// stays pending and is not consumed.
`timescale 1ns/1ps

module aes_block_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         reload_key,
  output logic [127:0] key_in,
  output logic [127:0] plain_in,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [1:0]   dbg_state,
  output logic [3:0]   dbg_cnt
);

  typedef enum logic [1:0] {
    LOAD_KEY   = 2'd0,
    LOAD_PLAIN = 2'd1,
    PRESENT    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   plain_q, plain_d;
  logic           byte_accept;

  // Outputs are decoded from state or taken straight from registers.
  assign in_ready  = (state_q != PRESENT);
  assign blk_valid = (state_q == PRESENT);
  assign key_in    = key_q;
  assign plain_in  = plain_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

  // Next-state logic: flush overrides everything, then per-state loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    plain_d     = plain_q;
    byte_accept = in_valid & in_ready;

    if (flush) begin
      // A byte offered alongside flush is dropped; a coincident block
      // handshake still completes downstream, but the loader restarts.
      state_d = LOAD_KEY;
      cnt_d   = 4'd0;
      key_d   = '0;
      plain_d = '0;
    end else begin
      case (state_q)
        LOAD_KEY: begin
          if (byte_accept) begin
            key_d[{cnt_q, 3'b000} +: 8] = in_byte;
            if (cnt_q == 4'd15) begin
              cnt_d   = 4'd0;
              state_d = LOAD_PLAIN;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        LOAD_PLAIN: begin
          if (byte_accept) begin
            plain_d[{cnt_q, 3'b000} +: 8] = in_byte;
            if (cnt_q == 4'd15) begin
              cnt_d   = 4'd0;
              state_d = PRESENT;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        PRESENT: begin
          // Key is retained when the next block reuses it.
          if (blk_ready) begin
            state_d = reload_key ? LOAD_KEY : LOAD_PLAIN;
          end
        end
        default: begin
          state_d = LOAD_KEY;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      plain_q <= plain_d;
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed testbench for aes_block_loader.
`timescale 1ns/1ps

module tb_aes_block_loader;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic         reload_key;
  logic [127:0] key_in;
  logic [127:0] plain_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_cnt;

  int tests_run;
  int tests_failed;

  logic [7:0] stream_a[32];

  localparam logic [127:0] KEY_A   = 128'h100f0e0d0c0b0a090807060504030201;
  localparam logic [127:0] PLAIN_A = 128'h00fffefdfcfbfaf9f8f7f6f5f4f3f2f1;
  localparam logic [127:0] PLAIN_R = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KEY_B   = 128'h2f2e2d2c2b2a29282726252423222120;
  localparam logic [127:0] PLAIN_B = 128'h4f4e4d4c4b4a49484746454443424140;

  aes_block_loader dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload_key (reload_key),
    .key_in     (key_in),
    .plain_in   (plain_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .dbg_state  (dbg_state),
    .dbg_cnt    (dbg_cnt)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: step one clock, then settle 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one byte for one cycle (in_valid left high).
  task automatic drive_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    step();
  endtask

  // Driver: one-cycle block handshake.
  task automatic do_handshake(input logic reload);
    reload_key = reload;
    blk_ready  = 1'b1;
    step();
    blk_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1 || key_in !== 128'h0 ||
        plain_in !== 128'h0 || dbg_state !== 2'd0 || dbg_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset: blk_valid=%b in_ready=%b key=%h plain=%h state=%0d cnt=%0d, required 0 1 0 0 0 0",
               blk_valid, in_ready, key_in, plain_in, dbg_state, dbg_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b blk_valid=%b, required 1 0", in_ready, blk_valid);
    end
  endtask

  task automatic test_back_to_back();
    int early;
    early = 0;
    reload_key = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (blk_valid !== 1'b0) early++;
      drive_byte(stream_a[i]);
    end
    in_valid = 1'b0;
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL b2b_early_valid: blk_valid high in %0d of cycles 1..32, required 0", early);
    end
    tests_run++;
    if (blk_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_cycle33: blk_valid=%b in_ready=%b, required 1 0", blk_valid, in_ready);
    end
    tests_run++;
    if (key_in !== KEY_A) begin
      tests_failed++;
      $display("FAIL b2b_key: got %h, required %h", key_in, KEY_A);
    end
    tests_run++;
    if (plain_in !== PLAIN_A) begin
      tests_failed++;
      $display("FAIL b2b_plain: got %h, required %h", plain_in, PLAIN_A);
    end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    in_valid = 1'b1;
    in_byte  = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_ready !== 1'b0 || blk_valid !== 1'b1 || key_in !== KEY_A ||
          plain_in !== PLAIN_A || dbg_cnt !== 4'd0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL hold: %0d of 10 held cycles disturbed, required 0", bad);
    end
    do_handshake(1'b1);
    in_valid = 1'b0;
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0 || dbg_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL hold_release: blk_valid=%b in_ready=%b state=%0d cnt=%0d, required 0 1 0 0",
               blk_valid, in_ready, dbg_state, dbg_cnt);
    end
    tests_run++;
    if (plain_in !== PLAIN_A || key_in !== KEY_A) begin
      tests_failed++;
      $display("FAIL hold_release_data: key=%h plain=%h, required %h %h", key_in, plain_in, KEY_A, PLAIN_A);
    end
  endtask

  task automatic test_toggle();
    int early;
    early = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++;
    if (key_in !== 128'h0 || plain_in !== 128'h0) begin
      tests_failed++;
      $display("FAIL toggle_flush: key=%h plain=%h, required 0 0", key_in, plain_in);
    end
    reload_key = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (blk_valid !== 1'b0) early++;
      drive_byte(stream_a[i]);
      if (i != 31) begin
        in_valid = 1'b0;
        in_byte  = 8'haa;
        if (blk_valid !== 1'b0) early++;
        step();
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (early != 0 || blk_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL toggle_valid: early=%0d blk_valid=%b, required 0 1", early, blk_valid);
    end
    tests_run++;
    if (key_in !== KEY_A || plain_in !== PLAIN_A) begin
      tests_failed++;
      $display("FAIL toggle_data: key=%h plain=%h, required %h %h", key_in, plain_in, KEY_A, PLAIN_A);
    end
  endtask

  task automatic test_key_reuse();
    int early;
    early = 0;
    do_handshake(1'b0);
    tests_run++;
    if (blk_valid !== 1'b0 || dbg_state !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reuse_state: blk_valid=%b state=%0d in_ready=%b, required 0 1 1",
               blk_valid, dbg_state, in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      if (blk_valid !== 1'b0) early++;
      drive_byte(8'(i));
    end
    in_valid = 1'b0;
    tests_run++;
    if (early != 0 || blk_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reuse_valid: early=%0d blk_valid=%b, required 0 1", early, blk_valid);
    end
    tests_run++;
    if (key_in !== KEY_A || plain_in !== PLAIN_R) begin
      tests_failed++;
      $display("FAIL reuse_data: key=%h plain=%h, required %h %h", key_in, plain_in, KEY_A, PLAIN_R);
    end
    do_handshake(1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) drive_byte(8'h80 + 8'(i));
    in_valid = 1'b0;
    tests_run++;
    if (dbg_cnt !== 4'd7 || key_in !== {KEY_A[127:56], 56'h86858483828180}) begin
      tests_failed++;
      $display("FAIL flush_partial: cnt=%0d key=%h, required 7 %h", dbg_cnt, key_in,
               {KEY_A[127:56], 56'h86858483828180});
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (dbg_cnt !== 4'd0 || key_in !== 128'h0 || plain_in !== 128'h0 ||
        dbg_state !== 2'd0 || blk_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: cnt=%0d key=%h plain=%h state=%0d blk_valid=%b, required 0 0 0 0 0",
               dbg_cnt, key_in, plain_in, dbg_state, blk_valid);
    end
    for (int i = 0; i < 16; i++) drive_byte(8'h20 + 8'(i));
    for (int i = 0; i < 16; i++) drive_byte(8'h40 + 8'(i));
    in_valid = 1'b0;
    tests_run++;
    if (blk_valid !== 1'b1 || key_in !== KEY_B || plain_in !== PLAIN_B) begin
      tests_failed++;
      $display("FAIL flush_next_block: blk_valid=%b key=%h plain=%h, required 1 %h %h",
               blk_valid, key_in, plain_in, KEY_B, PLAIN_B);
    end
    // Flush coincident with handshake restarts loading with cleared words.
    flush = 1'b1;
    do_handshake(1'b0);
    flush = 1'b0;
    tests_run++;
    if (dbg_state !== 2'd0 || key_in !== 128'h0 || blk_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_handshake: state=%0d key=%h blk_valid=%b, required 0 0 0",
               dbg_state, key_in, blk_valid);
    end
  endtask

  task automatic test_async_reset();
    reload_key = 1'b1;
    for (int i = 0; i < 16; i++) drive_byte(stream_a[i]);
    for (int i = 0; i < 9; i++) drive_byte(stream_a[16 + i]);
    in_byte  = stream_a[25];
    in_valid = 1'b1;
    tests_run++;
    if (dbg_state !== 2'd1 || dbg_cnt !== 4'd9) begin
      tests_failed++;
      $display("FAIL async_pre: state=%0d cnt=%0d, required 1 9", dbg_state, dbg_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1 || key_in !== 128'h0 ||
        plain_in !== 128'h0 || dbg_state !== 2'd0 || dbg_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: blk_valid=%b in_ready=%b key=%h plain=%h state=%0d cnt=%0d, required 0 1 0 0 0 0",
               blk_valid, in_ready, key_in, plain_in, dbg_state, dbg_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    flush      = 1'b0;
    in_byte    = 8'h00;
    in_valid   = 1'b0;
    reload_key = 1'b1;
    blk_ready  = 1'b0;
    rst        = 1'b0;
    for (int i = 0; i < 16; i++) stream_a[i] = 8'(i + 1);
    for (int i = 0; i < 15; i++) stream_a[16 + i] = 8'hf1 + 8'(i);
    stream_a[31] = 8'h00;

    test_reset();
    test_back_to_back();
    test_hold();
    test_toggle();
    test_key_reuse();
    test_flush();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
